// File: rtl/demux_t_t_t_1.sv
// Temporal (race-logic) demultiplexer.
// The arrival tick of the select edge chooses which output line carries the
// data edge. The chosen output rises at the causal time max(tx, ts) and stays
// high until the next gamma-cycle reset.
//
// Ports:
//   clk          block clock
//   grst         gamma-cycle reset, asynchronous active-high; its release starts a cycle
//   x            temporal data input (rising-edge encoded)
//   select_line  temporal select input (rising-edge encoded)
//   outputs      temporal outputs, at most one bit rises per gamma cycle
//   sel_time     captured select arrival time
//   sel_valid    sel_time holds a finite captured time
//   range_err    select arrived in the window but ts >= NUM_OUTPUTS
//   done         gamma window closed (tick reached GAMMA_CYCLE_WIDTH)
module demux_t_t_t_1 #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned NUM_OUTPUTS       = GAMMA_CYCLE_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      grst,
    input  logic                                      x,
    input  logic                                      select_line,
    output logic [NUM_OUTPUTS-1:0]                    outputs,
    output logic [$clog2(GAMMA_CYCLE_WIDTH+1)-1:0]    sel_time,
    output logic                                      sel_valid,
    output logic                                      range_err,
    output logic                                      done
);

    localparam int unsigned TW = $clog2(GAMMA_CYCLE_WIDTH + 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic                   x_seen_q, x_seen_d;
    logic [TW-1:0]          tx_q, tx_d;
    logic                   sel_valid_q, sel_valid_d;
    logic [TW-1:0]          sel_time_q, sel_time_d;
    logic                   range_err_q, range_err_d;
    logic                   done_q, done_d;
    logic [NUM_OUTPUTS-1:0] outputs_q, outputs_d;

    // Arrival times as seen at this edge: captured value, or the current tick
    // if the line is arriving right now.
    logic                   x_now, s_now;
    logic [TW-1:0]          tx_eff, ts_eff, fire_time;

    // State register
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state_q     <= S_RUN;
            tick_q      <= '0;
            x_seen_q    <= 1'b0;
            tx_q        <= '0;
            sel_valid_q <= 1'b0;
            sel_time_q  <= '0;
            range_err_q <= 1'b0;
            done_q      <= 1'b0;
            outputs_q   <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            x_seen_q    <= x_seen_d;
            tx_q        <= tx_d;
            sel_valid_q <= sel_valid_d;
            sel_time_q  <= sel_time_d;
            range_err_q <= range_err_d;
            done_q      <= done_d;
            outputs_q   <= outputs_d;
        end
    end

    // Next-state: capture arrivals and fire the selected output in RUN
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        x_seen_d    = x_seen_q;
        tx_d        = tx_q;
        sel_valid_d = sel_valid_q;
        sel_time_d  = sel_time_q;
        range_err_d = range_err_q;
        done_d      = done_q;
        outputs_d   = outputs_q;

        x_now     = x_seen_q | x;
        s_now     = sel_valid_q | select_line;
        tx_eff    = x_seen_q ? tx_q : tick_q;
        ts_eff    = sel_valid_q ? sel_time_q : tick_q;
        fire_time = (tx_eff > ts_eff) ? tx_eff : ts_eff;

        case (state_q)
            S_RUN: begin
                if (x && !x_seen_q) begin
                    x_seen_d = 1'b1;
                    tx_d     = tick_q;
                end
                if (select_line && !sel_valid_q) begin
                    sel_valid_d = 1'b1;
                    sel_time_d  = tick_q;
                    if (32'(tick_q) >= NUM_OUTPUTS) begin
                        range_err_d = 1'b1;
                    end
                end
                // Fire exactly once, at the edge where the later of the two lines lands.
                if (x_now && s_now && (tick_q == fire_time)) begin
                    for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
                        if (32'(ts_eff) == 32'(i)) begin
                            outputs_d[i] = 1'b1;
                        end
                    end
                end
                tick_d = tick_q + TW'(1);
                if (tick_q == TW'(GAMMA_CYCLE_WIDTH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                // Window closed: everything frozen until grst.
            end
            default: begin
                state_d = S_DONE;
            end
        endcase
    end

    assign outputs   = outputs_q;
    assign sel_time  = sel_time_q;
    assign sel_valid = sel_valid_q;
    assign range_err = range_err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_demux_t_t_t_1.sv
// Directed bench for demux_t_t_t_1: a 16-output instance and an 8-output
// instance share the stimulus so range errors can be exercised.
module tb_demux_t_t_t_1;

    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        grst;
    logic        x;
    logic        select_line;
    logic [15:0] outputs16;
    logic [4:0]  sel_time16;
    logic        sel_valid16, range_err16, done16;
    logic [7:0]  outputs8;
    logic [4:0]  sel_time8;
    logic        sel_valid8, range_err8, done8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_t_t_t_1 #(.GAMMA_CYCLE_WIDTH(16), .NUM_OUTPUTS(16)) u_dut16 (
        .clk(clk), .grst(grst), .x(x), .select_line(select_line),
        .outputs(outputs16), .sel_time(sel_time16), .sel_valid(sel_valid16),
        .range_err(range_err16), .done(done16)
    );

    demux_t_t_t_1 #(.GAMMA_CYCLE_WIDTH(16), .NUM_OUTPUTS(8)) u_dut8 (
        .clk(clk), .grst(grst), .x(x), .select_line(select_line),
        .outputs(outputs8), .sel_time(sel_time8), .sel_valid(sel_valid8),
        .range_err(range_err8), .done(done8)
    );

    typedef struct {
        int          ts;      // select edge (NEVER = never)
        int          tx;      // data edge
        int          fire;    // edge at which the output rises (NEVER = none)
        logic [15:0] exp16;
        logic [7:0]  exp8;
        logic [4:0]  exp_sel_time;
        logic        exp_valid;
        logic        exp_rerr8;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run one full gamma cycle for vector v, checking after every edge.
    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        grst = 1'b1;
        x = 1'b0;
        select_line = 1'b0;
        @(negedge clk);
        x = (v.tx == 0);
        select_line = (v.ts == 0);
        @(negedge clk);
        grst = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out16 e%0d", idx, k), 32'(outputs16), (k >= v.fire) ? 32'(v.exp16) : 32'd0);
            chk($sformatf("v%0d out8 e%0d", idx, k), 32'(outputs8), (k >= v.fire) ? 32'(v.exp8) : 32'd0);
            chk($sformatf("v%0d done e%0d", idx, k), 32'(done16), (k >= 15) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d rerr8 e%0d", idx, k), 32'(range_err8),
                (v.exp_rerr8 && k >= v.ts) ? 32'd1 : 32'd0);
            @(negedge clk);
            x = (k + 1 >= v.tx);
            select_line = (k + 1 >= v.ts);
        end
        chk($sformatf("v%0d sel_time", idx), 32'(sel_time16), 32'(v.exp_sel_time));
        chk($sformatf("v%0d sel_valid", idx), 32'(sel_valid16), 32'(v.exp_valid));
        chk($sformatf("v%0d rerr16", idx), 32'(range_err16), 32'd0);
        chk($sformatf("v%0d done8", idx), 32'(done8), 32'd1);
    endtask

    initial begin
        vecs[0] = '{ts: 3,  tx: 5,     fire: 5,     exp16: 16'h0008, exp8: 8'h08, exp_sel_time: 5'd3,  exp_valid: 1'b1, exp_rerr8: 1'b0};
        vecs[1] = '{ts: 7,  tx: 2,     fire: 7,     exp16: 16'h0080, exp8: 8'h80, exp_sel_time: 5'd7,  exp_valid: 1'b1, exp_rerr8: 1'b0};
        vecs[2] = '{ts: 4,  tx: 4,     fire: 4,     exp16: 16'h0010, exp8: 8'h10, exp_sel_time: 5'd4,  exp_valid: 1'b1, exp_rerr8: 1'b0};
        vecs[3] = '{ts: 0,  tx: 0,     fire: 0,     exp16: 16'h0001, exp8: 8'h01, exp_sel_time: 5'd0,  exp_valid: 1'b1, exp_rerr8: 1'b0};
        vecs[4] = '{ts: 15, tx: 1,     fire: 15,    exp16: 16'h8000, exp8: 8'h00, exp_sel_time: 5'd15, exp_valid: 1'b1, exp_rerr8: 1'b1};
        vecs[5] = '{ts: 16, tx: 1,     fire: NEVER, exp16: 16'h0000, exp8: 8'h00, exp_sel_time: 5'd0,  exp_valid: 1'b0, exp_rerr8: 1'b0};
        vecs[6] = '{ts: 10, tx: 2,     fire: 10,    exp16: 16'h0400, exp8: 8'h00, exp_sel_time: 5'd10, exp_valid: 1'b1, exp_rerr8: 1'b1};
        vecs[7] = '{ts: 3,  tx: NEVER, fire: NEVER, exp16: 16'h0000, exp8: 8'h00, exp_sel_time: 5'd3,  exp_valid: 1'b1, exp_rerr8: 1'b0};

        // Reset state
        grst = 1'b1;
        x = 1'b1;
        select_line = 1'b1;
        @(posedge clk);
        #1;
        chk("rst outputs", 32'(outputs16), 32'd0);
        chk("rst sel_time", 32'(sel_time16), 32'd0);
        chk("rst sel_valid", 32'(sel_valid16), 32'd0);
        chk("rst range_err", 32'(range_err16), 32'd0);
        chk("rst done", 32'(done16), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Mid-cycle abort: outputs[3] fires, then grst pulses between edges 6 and 7.
        grst = 1'b1;
        x = 1'b0;
        select_line = 1'b0;
        @(negedge clk);
        @(negedge clk);
        grst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) begin
                chk("abort pre out", 32'(outputs16), 32'h0008);
                chk("abort pre valid", 32'(sel_valid16), 32'd1);
            end
            @(negedge clk);
            x = (k + 1 >= 3);
            select_line = (k + 1 >= 3);
        end
        #2;
        grst = 1'b1;
        #1;
        chk("abort out", 32'(outputs16), 32'd0);
        chk("abort sel_time", 32'(sel_time16), 32'd0);
        chk("abort sel_valid", 32'(sel_valid16), 32'd0);
        chk("abort done", 32'(done16), 32'd0);
        x = 1'b0;
        select_line = 1'b0;
        @(negedge clk);
        grst = 1'b0;
        @(posedge clk);
        #1;
        chk("new e0 out", 32'(outputs16), 32'd0);
        @(negedge clk);
        x = 1'b1;
        select_line = 1'b1;
        @(posedge clk);
        #1;
        chk("new e1 out", 32'(outputs16), 32'h0002);
        chk("new e1 sel_time", 32'(sel_time16), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
